qubit_window_accum: RTL and testbench

- Sits directly downstream of the coordinate matcher in the 510 MHz pixel path.
- Buffers the two previous image rows and captures the 3x3 window around each matched qubit, using the matcher's trigger point (Qx+1, Qy). Window spans x in [Qx-1..Qx+1], y in [Qy-2..Qy].
- Sums the 9 pixels and thresholds the sum into an occupied/empty decision per qubit.
- At end of frame, publishes the per-qubit occupancy bitmask to the readout/sequencer logic.

---
 rtl/qubit_window_accum.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_qubit_window_accum.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qubit_window_accum.sv
// qubit_window_accum
//
// Captures the 3x3 pixel window around each qubit the coordinate matcher
// flags. The window is summed and compared against a threshold, which gives
// one occupied/empty decision per qubit. At the end of each frame the
// per-qubit decisions are published as a bitmask.
//
// Pixels arrive two per cycle (an even x and x+1). Two cascaded line buffers
// supply the same pair position from rows y-1 and y-2. A set of previous-pair
// registers supplies the two columns to the left.
//
// Ports:
//   i_clk, i_rst_n          pixel clock, asynchronous active-low reset
//   i_valid, i_curr_x/y     pixel pair valid and its coordinates (x even)
//   i_pix0, i_pix1          intensities at (x,y) and (x+1,y)
//   i_sync_lval/fval        line / frame valid
//   i_match_found           matcher hit for this pair
//   i_qubit_index           qubit that was hit
//   i_match_offset          0: trigger on pix0, 1: trigger on pix1
//   i_threshold             occupancy threshold (unsigned)
//   o_result_*              per-window result, valid two cycles after the hit
//   o_frame_done            one-cycle pulse, three cycles after fval falls
//   o_occupancy/o_seen_mask masks of the finished frame, held until next frame
//   o_dup_error             sticky: a qubit was captured twice in one frame
module qubit_window_accum #(
  parameter int NUM_QUBITS     = 64,
  parameter int QUBIT_ID_WIDTH = 6,
  parameter int COORD_WIDTH    = 11,
  parameter int PIX_WIDTH      = 12,
  parameter int IMG_WIDTH      = 1024,
  parameter int SUM_WIDTH      = PIX_WIDTH + 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [COORD_WIDTH-1:0]    i_curr_x,
  input  logic [COORD_WIDTH-1:0]    i_curr_y,
  input  logic [PIX_WIDTH-1:0]      i_pix0,
  input  logic [PIX_WIDTH-1:0]      i_pix1,
  input  logic                      i_sync_lval,
  input  logic                      i_sync_fval,
  input  logic                      i_match_found,
  input  logic [QUBIT_ID_WIDTH-1:0] i_qubit_index,
  input  logic                      i_match_offset,
  input  logic [SUM_WIDTH-1:0]      i_threshold,
  output logic                      o_result_valid,
  output logic [QUBIT_ID_WIDTH-1:0] o_result_index,
  output logic [SUM_WIDTH-1:0]      o_result_sum,
  output logic                      o_result_occupied,
  output logic                      o_frame_done,
  output logic [NUM_QUBITS-1:0]     o_occupancy,
  output logic [NUM_QUBITS-1:0]     o_seen_mask,
  output logic                      o_dup_error
);

  localparam int PAIRS  = IMG_WIDTH / 2;
  localparam int ADDR_W = $clog2(PAIRS);
  localparam int PAIR_W = 2 * PIX_WIDTH;
  localparam int WIN_W  = 9 * PIX_WIDTH;

  // Only the pair address bits of x are used. Bit 0 is always zero, and the
  // upper bits exceed the line length.
  logic unused_x;
  assign unused_x = ^{i_curr_x[0], i_curr_x[COORD_WIDTH-1:ADDR_W+1]};

  logic [ADDR_W-1:0] addr;
  assign addr = i_curr_x[ADDR_W:1];

  // State registers
  logic                      fval_q, fval_d;
  logic                      lval_q, lval_d;
  logic                      frame_active_q, frame_active_d;
  logic [PAIR_W-1:0]         prev_r0_q, prev_r0_d;
  logic [PAIR_W-1:0]         prev_r1_q, prev_r1_d;
  logic [PAIR_W-1:0]         prev_r2_q, prev_r2_d;
  logic                      s1_valid_q, s1_valid_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic [QUBIT_ID_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                      res_valid_q, res_valid_d;
  logic [QUBIT_ID_WIDTH-1:0] res_idx_q, res_idx_d;
  logic [SUM_WIDTH-1:0]      res_sum_q, res_sum_d;
  logic                      res_occ_q, res_occ_d;
  logic [NUM_QUBITS-1:0]     occ_q, occ_d;
  logic [NUM_QUBITS-1:0]     seen_q, seen_d;
  logic [NUM_QUBITS-1:0]     occ_out_q, occ_out_d;
  logic [NUM_QUBITS-1:0]     seen_out_q, seen_out_d;
  logic                      dup_q, dup_d;
  logic                      eof1_q, eof1_d;
  logic                      eof2_q, eof2_d;
  logic                      done_q, done_d;

  // Combinational helpers
  logic                 fval_rise, fval_fall, lval_rise, accept;
  logic                 row1_en, row2_en;
  logic [PAIR_W-1:0]    rd_a, rd_b;
  logic [PAIR_W-1:0]    cur_r1, cur_r2, use_r0, use_r1, use_r2;
  logic [SUM_WIDTH-1:0] win_sum;

  // Line buffers. Contents are never reset, because rows that lie above
  // the frame are masked out by the row checks instead.
  logic [PAIR_W-1:0] line_a [PAIRS];
  logic [PAIR_W-1:0] line_b [PAIRS];

  assign rd_a = line_a[addr];
  assign rd_b = line_b[addr];

  // Read-before-write: B takes the old A entry, so B always holds row y-2.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_a[addr] <= {i_pix1, i_pix0};
      line_b[addr] <= rd_a;
    end
  end

  // Pick three columns from the previous and current pair of one row.
  // The most significant slice is the rightmost column.
  function automatic logic [3*PIX_WIDTH-1:0] pick3(
    input logic [PAIR_W-1:0] prev,
    input logic [PAIR_W-1:0] cur,
    input logic              off
  );
    if (off)
      pick3 = {cur[PAIR_W-1:PIX_WIDTH], cur[PIX_WIDTH-1:0], prev[PAIR_W-1:PIX_WIDTH]};
    else
      pick3 = {cur[PIX_WIDTH-1:0], prev[PAIR_W-1:PIX_WIDTH], prev[PIX_WIDTH-1:0]};
  endfunction

  // Frame/line edge detection and the accept decision. Pairs are taken only
  // inside a frame whose start was seen. A reset in mid-frame therefore
  // ignores the rest of that frame and does not report its end.
  always_comb begin
    fval_rise = i_sync_fval & ~fval_q;
    fval_fall = ~i_sync_fval & fval_q & frame_active_q;
    lval_rise = i_sync_lval & ~lval_q;
    accept    = i_valid & i_sync_lval & i_sync_fval & (frame_active_q | fval_rise);
    row1_en   = (i_curr_y >= COORD_WIDTH'(1));
    row2_en   = (i_curr_y >= COORD_WIDTH'(2));
  end

  // Window assembly. The columns left of the line start read as zero
  // because the previous-pair registers are cleared at the line start.
  // Rows above the top of the image are zeroed by the row checks.
  always_comb begin
    cur_r1 = row1_en ? rd_a : '0;
    cur_r2 = row2_en ? rd_b : '0;
    use_r0 = lval_rise ? '0 : prev_r0_q;
    use_r1 = (lval_rise || !row1_en) ? '0 : prev_r1_q;
    use_r2 = (lval_rise || !row2_en) ? '0 : prev_r2_q;
  end

  // Adder tree over the captured window. The sum width covers 9 maximum
  // pixels, so the sum cannot overflow.
  always_comb begin
    win_sum = '0;
    for (int i = 0; i < 9; i++) begin
      win_sum = win_sum + SUM_WIDTH'(win_q[i*PIX_WIDTH +: PIX_WIDTH]);
    end
  end

  // Next-state logic for the pair registers, the pipeline, the masks and
  // the end-of-frame sequencing.
  always_comb begin
    fval_d         = i_sync_fval;
    lval_d         = i_sync_lval;
    frame_active_d = i_sync_fval & (frame_active_q | fval_rise);

    prev_r0_d = prev_r0_q;
    prev_r1_d = prev_r1_q;
    prev_r2_d = prev_r2_q;
    if (lval_rise) begin
      prev_r0_d = '0;
      prev_r1_d = '0;
      prev_r2_d = '0;
    end
    if (accept) begin
      prev_r0_d = {i_pix1, i_pix0};
      prev_r1_d = rd_a;
      prev_r2_d = rd_b;
    end

    // Stage 1: register the nine window pixels and the qubit index.
    s1_valid_d = accept & i_match_found;
    win_d      = win_q;
    s1_idx_d   = s1_idx_q;
    if (s1_valid_d) begin
      win_d = {pick3(use_r2, cur_r2, i_match_offset),
               pick3(use_r1, cur_r1, i_match_offset),
               pick3(use_r0, {i_pix1, i_pix0}, i_match_offset)};
      s1_idx_d = i_qubit_index;
    end

    // Stage 2: sum and threshold compare. The result fields hold their
    // value between pulses.
    res_valid_d = s1_valid_q;
    res_idx_d   = res_idx_q;
    res_sum_d   = res_sum_q;
    res_occ_d   = res_occ_q;
    if (s1_valid_q) begin
      res_idx_d = s1_idx_q;
      res_sum_d = win_sum;
      res_occ_d = (win_sum >= i_threshold);
    end

    // Working masks. A repeat capture flags an error, and the newest
    // decision replaces the older one.
    occ_d  = occ_q;
    seen_d = seen_q;
    dup_d  = dup_q;
    if (res_valid_q) begin
      if (seen_q[res_idx_q])
        dup_d = 1'b1;
      seen_d[res_idx_q] = 1'b1;
      occ_d[res_idx_q]  = res_occ_q;
    end

    // The end-of-frame delay lets every in-flight result retire. Any
    // result that retires on the copy edge is merged in before the copy.
    eof1_d     = fval_fall;
    eof2_d     = eof1_q;
    done_d     = eof2_q;
    occ_out_d  = occ_out_q;
    seen_out_d = seen_out_q;
    if (eof2_q) begin
      occ_out_d  = occ_d;
      seen_out_d = seen_d;
      occ_d      = '0;
      seen_d     = '0;
    end
  end

  // fval_q resets high. If fval is already high when reset is released,
  // it is not mistaken for the start of a new frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fval_q         <= 1'b1;
      lval_q         <= 1'b0;
      frame_active_q <= 1'b0;
      prev_r0_q      <= '0;
      prev_r1_q      <= '0;
      prev_r2_q      <= '0;
      s1_valid_q     <= 1'b0;
      win_q          <= '0;
      s1_idx_q       <= '0;
      res_valid_q    <= 1'b0;
      res_idx_q      <= '0;
      res_sum_q      <= '0;
      res_occ_q      <= 1'b0;
      occ_q          <= '0;
      seen_q         <= '0;
      occ_out_q      <= '0;
      seen_out_q     <= '0;
      dup_q          <= 1'b0;
      eof1_q         <= 1'b0;
      eof2_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      fval_q         <= fval_d;
      lval_q         <= lval_d;
      frame_active_q <= frame_active_d;
      prev_r0_q      <= prev_r0_d;
      prev_r1_q      <= prev_r1_d;
      prev_r2_q      <= prev_r2_d;
      s1_valid_q     <= s1_valid_d;
      win_q          <= win_d;
      s1_idx_q       <= s1_idx_d;
      res_valid_q    <= res_valid_d;
      res_idx_q      <= res_idx_d;
      res_sum_q      <= res_sum_d;
      res_occ_q      <= res_occ_d;
      occ_q          <= occ_d;
      seen_q         <= seen_d;
      occ_out_q      <= occ_out_d;
      seen_out_q     <= seen_out_d;
      dup_q          <= dup_d;
      eof1_q         <= eof1_d;
      eof2_q         <= eof2_d;
      done_q         <= done_d;
    end
  end

  assign o_result_valid    = res_valid_q;
  assign o_result_index    = res_idx_q;
  assign o_result_sum      = res_sum_q;
  assign o_result_occupied = res_occ_q;
  assign o_frame_done      = done_q;
  assign o_occupancy       = occ_out_q;
  assign o_seen_mask       = seen_out_q;
  assign o_dup_error       = dup_q;

endmodule

// File: tb/tb_qubit_window_accum.sv
// Testbench for qubit_window_accum.
// Drives small frames (16 pixels wide) built from directed images. Each
// image has hand-computed window sums. A queue of expected results, each
// with its due cycle, is compared with the outputs after every clock edge.
module tb_qubit_window_accum;

  localparam int NQ  = 64;
  localparam int IDW = 6;
  localparam int CW  = 11;
  localparam int PW  = 12;
  localparam int SW  = 16;

  logic           clk = 1'b0;
  logic           rstN = 1'b0;
  logic           iValid, iLval, iFval, iMatch, iOff;
  logic [CW-1:0]  iX, iY;
  logic [PW-1:0]  iPix0, iPix1;
  logic [IDW-1:0] iIdx;
  logic [SW-1:0]  iThr;
  logic           oResValid, oResOcc, oFrameDone, oDup;
  logic [IDW-1:0] oResIdx;
  logic [SW-1:0]  oResSum;
  logic [NQ-1:0]  oOcc, oSeen;

  qubit_window_accum dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(iValid), .i_curr_x(iX), .i_curr_y(iY),
    .i_pix0(iPix0), .i_pix1(iPix1), .i_sync_lval(iLval), .i_sync_fval(iFval),
    .i_match_found(iMatch), .i_qubit_index(iIdx), .i_match_offset(iOff),
    .i_threshold(iThr), .o_result_valid(oResValid), .o_result_index(oResIdx),
    .o_result_sum(oResSum), .o_result_occupied(oResOcc), .o_frame_done(oFrameDone),
    .o_occupancy(oOcc), .o_seen_mask(oSeen), .o_dup_error(oDup)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [IDW-1:0] idx;
    logic [SW-1:0]  sum;
    logic           occ;
  } exp_t;

  exp_t          expQ[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            fdDue = -100;
  bit            prevFval = 1'b0;
  bit            tbActive = 1'b0;
  int            mN = 0;
  int            mX[4], mY[4], mOff[4], mIdx[4], mSum[4];
  bit            mOcc[4];
  logic [NQ-1:0] expOcc, expSeen;
  logic          expDup;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int pixVal(input int img, input int x, input int y);
    case (img)
      1: return (x >= 8 && x <= 10 && y >= 3 && y <= 5) ? 200 : 100;
      2: return (x >= 9 && x <= 11 && y >= 3 && y <= 5) ? 50 : 100;
      3: return 4095;
      default: return 100;
    endcase
  endfunction

  task automatic addMatch(input int x, y, off, idx, sum, input bit occ);
    mX[mN] = x; mY[mN] = y; mOff[mN] = off; mIdx[mN] = idx; mSum[mN] = sum; mOcc[mN] = occ;
    mN++;
  endtask

  // Drive one cycle of inputs, advance one clock, then check the outputs
  // against the expected-result queue and the frame-done expectation.
  task automatic applyStimulus(input bit v, lv, fv, input int x, y, p0, p1,
                               input bit mt, input int idx, off, esum, input bit eocc);
    iValid = v; iLval = lv; iFval = fv;
    iX = CW'(x); iY = CW'(y); iPix0 = PW'(p0); iPix1 = PW'(p1);
    iMatch = mt; iIdx = IDW'(idx); iOff = off[0];
    if (v && lv && fv && mt && tbActive)
      expQ.push_back('{cyc + 2, IDW'(idx), SW'(esum), eocc});
    if (!fv && prevFval && tbActive)
      fdDue = cyc + 3;
    prevFval = fv;
    @(posedge clk);
    #1;
    cyc++;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      checkOutput("result_valid", 64'(oResValid), 64'd1);
      checkOutput("result_index", 64'(oResIdx), 64'(expQ[0].idx));
      checkOutput("result_sum", 64'(oResSum), 64'(expQ[0].sum));
      checkOutput("result_occupied", 64'(oResOcc), 64'(expQ[0].occ));
      void'(expQ.pop_front());
    end else begin
      checkOutput("result_valid_idle", 64'(oResValid), 64'd0);
    end
    if (cyc == fdDue) begin
      checkOutput("frame_done", 64'(oFrameDone), 64'd1);
      checkOutput("occupancy", oOcc, expOcc);
      checkOutput("seen_mask", oSeen, expSeen);
      checkOutput("dup_error", 64'(oDup), 64'(expDup));
    end else begin
      checkOutput("frame_done_idle", 64'(oFrameDone), 64'd0);
    end
  endtask

  task automatic idleCycles(input int n, input bit fv);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 1'b0, fv, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Assert reset asynchronously in the middle of a cycle and check that
  // every output clears at once.
  task automatic doReset();
    checkOutput("dup_sticky", 64'(oDup), 64'd1);
    checkOutput("occupancy_held", oOcc, expOcc);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_result_valid", 64'(oResValid), 64'd0);
    checkOutput("rst_result_index", 64'(oResIdx), 64'd0);
    checkOutput("rst_result_sum", 64'(oResSum), 64'd0);
    checkOutput("rst_result_occupied", 64'(oResOcc), 64'd0);
    checkOutput("rst_frame_done", 64'(oFrameDone), 64'd0);
    checkOutput("rst_occupancy", oOcc, 64'd0);
    checkOutput("rst_seen_mask", oSeen, 64'd0);
    checkOutput("rst_dup_error", 64'(oDup), 64'd0);
    expQ.delete();
    tbActive = 1'b0;
    fdDue = -100;
    @(posedge clk);
    #1;
    cyc++;
    rstN = 1'b1;
  endtask

  task automatic runFrame(input int img, input int rows, input int thr, input int abortRow);
    int hit;
    iThr = SW'(thr);
    tbActive = 1'b1;
    for (int y = 0; y < rows; y++) begin
      idleCycles(1, 1'b1);
      if (y == abortRow)
        doReset();
      for (int x = 0; x < 16; x += 2) begin
        hit = -1;
        for (int m = 0; m < mN; m++)
          if (mX[m] == x && mY[m] == y) hit = m;
        if (hit >= 0)
          applyStimulus(1'b1, 1'b1, 1'b1, x, y, pixVal(img, x, y), pixVal(img, x + 1, y),
                        1'b1, mIdx[hit], mOff[hit], mSum[hit], mOcc[hit]);
        else
          applyStimulus(1'b1, 1'b1, 1'b1, x, y, pixVal(img, x, y), pixVal(img, x + 1, y),
                        1'b0, 0, 0, 0, 1'b0);
      end
    end
    idleCycles(6, 1'b0);
    mN = 0;
  endtask

  initial begin
    iValid = 0; iLval = 0; iFval = 0; iMatch = 0; iOff = 0;
    iX = '0; iY = '0; iPix0 = '0; iPix1 = '0; iIdx = '0; iThr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_result_valid", 64'(oResValid), 64'd0);
    checkOutput("init_result_sum", 64'(oResSum), 64'd0);
    checkOutput("init_frame_done", 64'(oFrameDone), 64'd0);
    checkOutput("init_occupancy", oOcc, 64'd0);
    checkOutput("init_seen_mask", oSeen, 64'd0);
    checkOutput("init_dup_error", 64'(oDup), 64'd0);
    rstN = 1'b1;
    idleCycles(3, 1'b0);

    // Interior window with offset 0: columns 8..10, rows 3..5, all 200.
    addMatch(10, 5, 0, 3, 1800, 1'b1);
    expOcc = 64'h8; expSeen = 64'h8; expDup = 1'b0;
    runFrame(1, 6, 1500, -1);

    // Offset 1: columns 9..11, rows 3..5, all 50.
    addMatch(10, 5, 1, 4, 450, 1'b0);
    expOcc = 64'h0; expSeen = 64'h10; expDup = 1'b0;
    runFrame(2, 6, 1500, -1);

    // Left and top edges, all 4095, with the threshold one above 3 pixels.
    addMatch(0, 0, 1, 2, 8190, 1'b0);
    addMatch(0, 1, 1, 6, 16380, 1'b1);
    addMatch(0, 2, 0, 10, 12285, 1'b0);
    addMatch(4, 2, 0, 8, 36855, 1'b1);
    expOcc = (64'd1 << 6) | (64'd1 << 8);
    expSeen = (64'd1 << 2) | (64'd1 << 6) | (64'd1 << 8) | (64'd1 << 10);
    expDup = 1'b0;
    runFrame(3, 3, 12286, -1);

    // Three qubits. The last match is on the final pair, so fval drops
    // right after it. Sum 900 equals the threshold, which counts as occupied.
    addMatch(4, 0, 0, 5, 300, 1'b0);
    addMatch(4, 3, 0, 0, 900, 1'b1);
    addMatch(14, 3, 0, 9, 900, 1'b1);
    expOcc = (64'd1 << 0) | (64'd1 << 9);
    expSeen = (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 9);
    expDup = 1'b0;
    runFrame(4, 4, 900, -1);

    // Same qubit twice. The second result (occupied) wins.
    addMatch(4, 0, 0, 12, 300, 1'b0);
    addMatch(4, 3, 0, 12, 900, 1'b1);
    expOcc = 64'd1 << 12; expSeen = 64'd1 << 12; expDup = 1'b1;
    runFrame(4, 4, 900, -1);

    // Reset in mid-frame. Matches after the reset give no result and no frame_done.
    addMatch(4, 0, 0, 20, 300, 1'b0);
    addMatch(4, 3, 0, 21, 900, 1'b1);
    runFrame(4, 4, 900, 2);

    // Clean frame after the reset.
    addMatch(4, 3, 0, 30, 900, 1'b1);
    expOcc = 64'd1 << 30; expSeen = 64'd1 << 30; expDup = 1'b0;
    runFrame(4, 4, 900, -1);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
